// File: rtl/instr_decode_stage.sv
// Decoupled instruction decode: raw instruction in, registered control bundle out.
// Latency: 1 cycle from accept to dec_valid; sustains 1 instruction per cycle.
// Backpressure: a 1-entry skid register absorbs one decode while execute stalls; instr_ready drops once it is full.
module instr_decode_stage #(
  parameter int INSTR_BITS    = 16,
  parameter int REG_ADDR_BITS = 4,
  parameter int IMM_BITS      = 8,
  parameter int DATA_BITS     = 16,
  parameter int SIGN_EXT_IMM  = 0,
  parameter int COUNT_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [INSTR_BITS-1:0]    instr,
  input  logic                     flush,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [REG_ADDR_BITS-1:0] dec_rd_addr,
  output logic [REG_ADDR_BITS-1:0] dec_rs_addr,
  output logic [REG_ADDR_BITS-1:0] dec_rt_addr,
  output logic [2:0]               dec_nzp,
  output logic [DATA_BITS-1:0]     dec_imm,
  output logic                     dec_reg_write_en,
  output logic                     dec_alu_out_mux,
  output logic                     dec_mem_read_en,
  output logic                     dec_mem_write_en,
  output logic                     dec_nzp_write_en,
  output logic                     dec_pc_mux,
  output logic                     dec_ret,
  output logic [1:0]               dec_alu_arith_mux,
  output logic [1:0]               dec_reg_input_mux,
  output logic                     dec_illegal,
  output logic                     err_illegal,
  input  logic                     err_clear,
  output logic [COUNT_BITS-1:0]    decode_count
);

  typedef struct packed {
    logic [REG_ADDR_BITS-1:0] rd;
    logic [REG_ADDR_BITS-1:0] rs;
    logic [REG_ADDR_BITS-1:0] rt;
    logic [2:0]               nzp;
    logic [DATA_BITS-1:0]     imm;
    logic                     reg_write_en;
    logic                     alu_out_mux;
    logic                     mem_read_en;
    logic                     mem_write_en;
    logic                     nzp_write_en;
    logic                     pc_mux;
    logic                     ret;
    logic [1:0]               alu_arith_mux;
    logic [1:0]               reg_input_mux;
    logic                     illegal;
  } bundle_t;

  localparam int RD_MSB = INSTR_BITS - 5;
  localparam int RS_MSB = RD_MSB - REG_ADDR_BITS;
  localparam int RT_MSB = RS_MSB - REG_ADDR_BITS;

  bundle_t                 dec_new;
  bundle_t                 out_q, out_d;
  bundle_t                 skid_q, skid_d;
  logic                    out_vld_q, out_vld_d;
  logic                    skid_vld_q, skid_vld_d;
  logic                    err_q, err_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic [3:0]              op;
  logic signed [IMM_BITS-1:0] imm_s;
  logic                    accept;
  logic                    pop;

  // Skid full means the next decode has nowhere to go; flush and reset also refuse new work.
  assign instr_ready = !skid_vld_q && !flush && !reset;
  assign accept      = instr_valid && instr_ready;
  assign pop         = out_vld_q && dec_ready && !flush;

  assign op    = instr[INSTR_BITS-1 -: 4];
  assign imm_s = instr[IMM_BITS-1:0];

  // Combinational decode of the incoming raw instruction into a control bundle.
  always_comb begin
    dec_new     = '0;
    dec_new.rd  = instr[RD_MSB -: REG_ADDR_BITS];
    dec_new.rs  = instr[RS_MSB -: REG_ADDR_BITS];
    dec_new.rt  = instr[RT_MSB -: REG_ADDR_BITS];
    dec_new.nzp = instr[RD_MSB -: 3];
    if (SIGN_EXT_IMM != 0) begin
      dec_new.imm = DATA_BITS'(imm_s);
    end else begin
      dec_new.imm = DATA_BITS'(instr[IMM_BITS-1:0]);
    end
    case (op)
      4'h1: dec_new.pc_mux = 1'b1;
      4'h2: begin
        dec_new.nzp_write_en = 1'b1;
        dec_new.alu_out_mux  = 1'b1;
      end
      4'h3, 4'h4, 4'h5, 4'h6: begin
        dec_new.reg_write_en  = 1'b1;
        dec_new.reg_input_mux = 2'b00;
        dec_new.alu_arith_mux = 2'(op - 4'h3);
      end
      4'h7: begin
        dec_new.mem_read_en   = 1'b1;
        dec_new.reg_write_en  = 1'b1;
        dec_new.reg_input_mux = 2'b10;
      end
      4'h8: dec_new.mem_write_en = 1'b1;
      4'h9: begin
        dec_new.reg_write_en  = 1'b1;
        dec_new.reg_input_mux = 2'b01;
      end
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: dec_new.illegal = 1'b1;
      4'hF: dec_new.ret = 1'b1;
      default: ;
    endcase
  end

  // Next state of the output/skid pair; skid always drains into OUT before new decodes, preserving order.
  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
        if (accept) begin
          skid_d     = dec_new;
          skid_vld_d = 1'b1;
        end
      end else if (accept) begin
        out_d     = dec_new;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec_new;
      skid_vld_d = 1'b1;
    end
  end

  // Sticky error (set wins over clear) and saturating consumed-bundle counter.
  always_comb begin
    err_d   = err_q;
    count_d = count_q;
    if (err_clear) begin
      err_d = 1'b0;
    end
    if (pop && out_q.illegal) begin
      err_d = 1'b1;
    end
    if (pop && (count_q != {COUNT_BITS{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // State registers, cleared asynchronously so outputs go quiet without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign dec_valid         = out_vld_q;
  assign dec_rd_addr       = out_q.rd;
  assign dec_rs_addr       = out_q.rs;
  assign dec_rt_addr       = out_q.rt;
  assign dec_nzp           = out_q.nzp;
  assign dec_imm           = out_q.imm;
  assign dec_reg_write_en  = out_q.reg_write_en;
  assign dec_alu_out_mux   = out_q.alu_out_mux;
  assign dec_mem_read_en   = out_q.mem_read_en;
  assign dec_mem_write_en  = out_q.mem_write_en;
  assign dec_nzp_write_en  = out_q.nzp_write_en;
  assign dec_pc_mux        = out_q.pc_mux;
  assign dec_ret           = out_q.ret;
  assign dec_alu_arith_mux = out_q.alu_arith_mux;
  assign dec_reg_input_mux = out_q.reg_input_mux;
  assign dec_illegal       = out_q.illegal;
  assign err_illegal       = err_q;
  assign decode_count      = count_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: a zero-extend/16-bit-count instance and a sign-extend/2-bit-count instance share stimulus.
// Latency: decoded bundles checked one cycle after acceptance.
// Backpressure: exercised by holding dec_ready low to fill OUT and SKID.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic reset, instr_valid, flush, dec_ready, err_clear;
  logic [15:0] instr;

  logic        ready_a, valid_a;
  logic [3:0]  rd_a, rs_a, rt_a;
  logic [2:0]  nzp_a;
  logic [15:0] imm_a;
  logic        rwe_a, aom_a, mre_a, mwe_a, nwe_a, pcm_a, ret_a, ill_a, err_a;
  logic [1:0]  arith_a, inmux_a;
  logic [15:0] cnt_a;

  logic        ready_b, valid_b;
  logic [3:0]  rd_b, rs_b, rt_b;
  logic [2:0]  nzp_b;
  logic [15:0] imm_b;
  logic        rwe_b, aom_b, mre_b, mwe_b, nwe_b, pcm_b, ret_b, ill_b, err_b;
  logic [1:0]  arith_b, inmux_b;
  logic [1:0]  cnt_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.SIGN_EXT_IMM(0), .COUNT_BITS(16)) dut_a (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready_a), .instr(instr),
    .flush(flush), .dec_valid(valid_a), .dec_ready(dec_ready),
    .dec_rd_addr(rd_a), .dec_rs_addr(rs_a), .dec_rt_addr(rt_a), .dec_nzp(nzp_a), .dec_imm(imm_a),
    .dec_reg_write_en(rwe_a), .dec_alu_out_mux(aom_a), .dec_mem_read_en(mre_a),
    .dec_mem_write_en(mwe_a), .dec_nzp_write_en(nwe_a), .dec_pc_mux(pcm_a), .dec_ret(ret_a),
    .dec_alu_arith_mux(arith_a), .dec_reg_input_mux(inmux_a), .dec_illegal(ill_a),
    .err_illegal(err_a), .err_clear(err_clear), .decode_count(cnt_a)
  );

  instr_decode_stage #(.SIGN_EXT_IMM(1), .COUNT_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready_b), .instr(instr),
    .flush(flush), .dec_valid(valid_b), .dec_ready(dec_ready),
    .dec_rd_addr(rd_b), .dec_rs_addr(rs_b), .dec_rt_addr(rt_b), .dec_nzp(nzp_b), .dec_imm(imm_b),
    .dec_reg_write_en(rwe_b), .dec_alu_out_mux(aom_b), .dec_mem_read_en(mre_b),
    .dec_mem_write_en(mwe_b), .dec_nzp_write_en(nwe_b), .dec_pc_mux(pcm_b), .dec_ret(ret_b),
    .dec_alu_arith_mux(arith_b), .dec_reg_input_mux(inmux_b), .dec_illegal(ill_b),
    .err_illegal(err_b), .err_clear(err_clear), .decode_count(cnt_b)
  );

  // ctrl bit order: reg_we, alu_out_mux, mem_rd, mem_wr, nzp_we, pc_mux, ret, arith[1:0], input_mux[1:0], illegal
  wire [11:0] ctrl_a = {rwe_a, aom_a, mre_a, mwe_a, nwe_a, pcm_a, ret_a, arith_a, inmux_a, ill_a};
  wire [43:0] bundle_a = {valid_a, ctrl_a, rd_a, rs_a, rt_a, nzp_a, imm_a};

  typedef struct {
    logic [15:0] instr;
    logic [11:0] ctrl;
    logic [11:0] regs;
    logic [2:0]  nzp;
    logic [15:0] imm_z;
    logic [15:0] imm_s;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    flush = 1'b0;
    err_clear = 1'b0;
    dec_ready = 1'b0;
    instr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 12'h000, 12'h000, 3'b000, 16'h0000, 16'h0000};
    vecs[1]  = '{16'h1A00, 12'h040, 12'hA00, 3'b101, 16'h0000, 16'h0000};
    vecs[2]  = '{16'h2345, 12'h480, 12'h345, 3'b001, 16'h0045, 16'h0045};
    vecs[3]  = '{16'h3123, 12'h800, 12'h123, 3'b000, 16'h0023, 16'h0023};
    vecs[4]  = '{16'h4321, 12'h808, 12'h321, 3'b001, 16'h0021, 16'h0021};
    vecs[5]  = '{16'h5000, 12'h810, 12'h000, 3'b000, 16'h0000, 16'h0000};
    vecs[6]  = '{16'h6FED, 12'h818, 12'hFED, 3'b111, 16'h00ED, 16'hFFED};
    vecs[7]  = '{16'h7456, 12'hA04, 12'h456, 3'b010, 16'h0056, 16'h0056};
    vecs[8]  = '{16'h8789, 12'h100, 12'h789, 3'b011, 16'h0089, 16'hFF89};
    vecs[9]  = '{16'h91F0, 12'h802, 12'h1F0, 3'b000, 16'h00F0, 16'hFFF0};
    vecs[10] = '{16'hA000, 12'h001, 12'h000, 3'b000, 16'h0000, 16'h0000};
    vecs[11] = '{16'hB123, 12'h001, 12'h123, 3'b000, 16'h0023, 16'h0023};
    vecs[12] = '{16'hC800, 12'h001, 12'h800, 3'b100, 16'h0000, 16'h0000};
    vecs[13] = '{16'hD0FF, 12'h001, 12'h0FF, 3'b000, 16'h00FF, 16'hFFFF};
    vecs[14] = '{16'hE555, 12'h001, 12'h555, 3'b010, 16'h0055, 16'h0055};
    vecs[15] = '{16'hFC00, 12'h020, 12'hC00, 3'b110, 16'h0000, 16'h0000};

    // Reset state, sampled while reset is held.
    reset = 1'b1; instr_valid = 1'b0; flush = 1'b0; err_clear = 1'b0; dec_ready = 1'b0; instr = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {20'h0, bundle_a, err_a, cnt_a}, 64'h0);
    check("reset_ready_low", {63'h0, ready_a}, 64'h0);
    reset = 1'b0;
    #1;
    check("post_reset_ready", {63'h0, ready_a}, 64'h1);

    // Basic decode of ADD r1, r2, r3.
    dec_ready = 1'b1; instr_valid = 1'b1; instr = 16'h3123;
    step();
    instr_valid = 1'b0;
    check("basic_bundle", {20'h0, bundle_a}, {20'h0, 1'b1, 12'h800, 12'h123, 3'b000, 16'h0023});
    step();
    check("basic_count", {48'h0, cnt_a}, 64'd1);
    check("basic_drained", {63'h0, valid_a}, 64'h0);

    // Full opcode table streamed back-to-back with execute always ready.
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      instr_valid = 1'b1;
      instr = vecs[i].instr;
      step();
      check($sformatf("table_%0h", vecs[i].instr), {20'h0, bundle_a},
            {20'h0, 1'b1, vecs[i].ctrl, vecs[i].regs, vecs[i].nzp, vecs[i].imm_z});
      check($sformatf("sext_%0h", vecs[i].instr), {48'h0, imm_b}, {48'h0, vecs[i].imm_s});
    end
    instr_valid = 1'b0;
    step();
    check("table_count", {48'h0, cnt_a}, 64'd16);
    check("table_count_sat", {62'h0, cnt_b}, 64'd3);
    check("table_err_set", {62'h0, err_a, err_b}, 64'h3);

    // Sticky error clear, then set-beats-clear.
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("err_cleared", {63'h0, err_a}, 64'h0);
    dec_ready = 1'b0; instr_valid = 1'b1; instr = 16'hA000;
    step();
    instr_valid = 1'b0;
    check("err_before_pop", {62'h0, ill_a, err_a}, 64'h2);
    dec_ready = 1'b1; err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("err_set_wins", {62'h0, err_a, err_b}, 64'h3);
    check("illegal_count", {48'h0, cnt_a}, 64'd17);

    // Backpressure: fill OUT and SKID, hold a third, then drain in order.
    dec_ready = 1'b0; instr_valid = 1'b1; instr = 16'h9105;
    step();
    instr = 16'h4321;
    step();
    instr = 16'h5000;
    #1;
    check("bp_ready_low", {63'h0, ready_a}, 64'h0);
    check("bp_out_const", {20'h0, bundle_a}, {20'h0, 1'b1, 12'h802, 12'h105, 3'b000, 16'h0005});
    step();
    check("bp_stable", {20'h0, bundle_a}, {20'h0, 1'b1, 12'h802, 12'h105, 3'b000, 16'h0005});
    dec_ready = 1'b1;
    step();
    check("bp_out_sub", {20'h0, bundle_a}, {20'h0, 1'b1, 12'h808, 12'h321, 3'b001, 16'h0021});
    step();
    instr_valid = 1'b0;
    check("bp_out_mul", {20'h0, bundle_a}, {20'h0, 1'b1, 12'h810, 12'h000, 3'b000, 16'h0000});
    step();
    check("bp_drained", {63'h0, valid_a}, 64'h0);
    check("bp_count", {48'h0, cnt_a}, 64'd20);

    // Flush with both registers full and execute ready.
    dec_ready = 1'b0; instr_valid = 1'b1; instr = 16'h3123;
    step();
    instr = 16'h4321;
    step();
    instr = 16'h5000; dec_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush_ready_low", {63'h0, ready_a}, 64'h0);
    step();
    flush = 1'b0; instr_valid = 1'b0;
    #1;
    check("flush_valid_low", {63'h0, valid_a}, 64'h0);
    check("flush_count", {48'h0, cnt_a}, 64'd20);
    check("flush_ready_back", {63'h0, ready_a}, 64'h1);
    step();
    check("flush_stays_empty", {63'h0, valid_a}, 64'h0);

    // Asynchronous reset in the middle of a stall, between clock edges.
    dec_ready = 1'b0; instr_valid = 1'b1; instr = 16'h7456;
    step();
    instr_valid = 1'b0;
    check("stall_valid", {63'h0, valid_a}, 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_a", {20'h0, bundle_a, err_a, cnt_a}, 64'h0);
    check("async_reset_b", {44'h0, valid_b, imm_b, cnt_b, err_b}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_release_ready", {63'h0, ready_a}, 64'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
